// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: FSM states, spi_core register addresses and CTRL bit positions for spi_xfer_arbiter.
package spi_arb_pkg;
  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SS, ST_TX, ST_GO, ST_WAIT, ST_RX, ST_RSP
  } state_e;
  localparam logic [7:0] SPI_ADDR_TX0 = 8'h00;
  localparam logic [7:0] SPI_ADDR_RX0 = 8'h00;
  localparam logic [7:0] SPI_ADDR_CTRL = 8'h10;
  localparam logic [7:0] SPI_ADDR_DIVIDER = 8'h14;
  localparam logic [7:0] SPI_ADDR_SS = 8'h18;
  localparam int CTRL_GO = 8;
  localparam int CTRL_IE = 12;
  localparam int CTRL_ASS = 13;
endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
module spi_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [IW-1:0] j;
  assign any_o = |req_i;
  // scan offsets from farthest to nearest so the nearest valid index wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one spi_core among NREQ requesters, sequencing SS/TX/CTRL, wait, RX.
// Define SPI_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT_CYC cycles.
module spi_xfer_arbiter import spi_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int SS_NB = 8,
  parameter int CHAR_LEN = 32,
  parameter logic [15:0] CLK_DIV = 16'd1
`ifdef SPI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*32-1:0]       req_data_i,
  input  logic [NREQ*SS_NB-1:0]    req_ss_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     rsp_valid_o,
  output logic [$clog2(NREQ)-1:0]  rsp_id_o,
  output logic [31:0]              rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     busy_o,
  output logic                     re_o,
  output logic                     we_o,
  output logic [7:0]               addr_o,
  output logic [31:0]              wdata_o,
  output logic [3:0]               be_o,
  input  logic [31:0]              rdata_i,
  input  logic                     error_i,
  input  logic                     intr_i
);
  localparam int IW = $clog2(NREQ);
  localparam logic [31:0] CTRL_WORD =
    32'((1 << CTRL_GO) | (1 << CTRL_IE) | (1 << CTRL_ASS) | (CHAR_LEN & 'h7F));
  state_e state_q, state_d;
  logic boot_q, err_q, err_d, first_q;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, idx;
  logic [31:0] data_q, data_d, rx_q, rx_d;
  logic [SS_NB-1:0] ss_q, ss_d;
  logic [NREQ-1:0] gnt;
  logic any;
  logic [31:0] rd [NREQ];
  logic [SS_NB-1:0] rs [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd[g] = req_data_i[g*32 +: 32];
    assign rs[g] = req_ss_i[g*SS_NB +: SS_NB];
  end
  spi_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx),
    .any_o(any)
  );
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i)
    cnt_q <= (rst_i || state_q != ST_WAIT) ? 16'd0 : cnt_q + 16'd1;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    data_d = data_q;
    ss_d = ss_q;
    err_d = err_q;
    rx_d = rx_q;
    req_ready_o = '0;
    we_o = 1'b0;
    re_o = 1'b0;
    addr_o = '0;
    wdata_o = '0;
    case (state_q)
      ST_INIT: if (!boot_q) begin
        we_o = 1'b1;
        addr_o = SPI_ADDR_DIVIDER;
        wdata_o = {16'd0, CLK_DIV};
        state_d = ST_IDLE;
      end
      ST_IDLE: if (any) begin
        req_ready_o = gnt;
        id_d = idx;
        data_d = rd[idx];
        ss_d = rs[idx];
        err_d = 1'b0;
        ptr_d = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        state_d = ST_SS;
      end
      ST_SS: begin
        we_o = 1'b1;
        addr_o = SPI_ADDR_SS;
        wdata_o = 32'(ss_q);
        state_d = ST_TX;
      end
      ST_TX: begin
        we_o = 1'b1;
        addr_o = SPI_ADDR_TX0;
        wdata_o = data_q;
        state_d = ST_GO;
      end
      ST_GO: begin
        we_o = 1'b1;
        addr_o = SPI_ADDR_CTRL;
        wdata_o = CTRL_WORD;
        state_d = ST_WAIT;
      end
      // first WAIT cycle ignores intr_i so a level left over from a previous transfer is skipped
      ST_WAIT: if (!first_q && intr_i) state_d = ST_RX;
`ifdef SPI_ARB_TIMEOUT_EN
      else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
        we_o = 1'b1;
        addr_o = SPI_ADDR_CTRL;
        err_d = 1'b1;
        state_d = ST_RSP;
      end
`endif
      ST_RX: begin
        re_o = 1'b1;
        addr_o = SPI_ADDR_RX0;
        rx_d = rdata_i;
        state_d = ST_RSP;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((we_o || re_o) && error_i) err_d = 1'b1;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= ST_INIT;
      boot_q <= 1'b1;
      first_q <= 1'b0;
      ptr_q <= '0;
      id_q <= '0;
      data_q <= '0;
      ss_q <= '0;
      err_q <= 1'b0;
      rx_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q <= 1'b0;
      first_q <= state_q == ST_GO;
      ptr_q <= ptr_d;
      id_q <= id_d;
      data_q <= data_d;
      ss_q <= ss_d;
      err_q <= err_d;
      rx_q <= rx_d;
    end
  assign be_o = 4'hF;
  assign busy_o = state_q != ST_IDLE && !boot_q;
  assign rsp_valid_o = state_q == ST_RSP;
  assign rsp_err_o = rsp_valid_o && err_q;
  assign rsp_id_o = rsp_valid_o ? id_q : '0;
  assign rsp_data_o = (rsp_valid_o && !err_q) ? rx_q : '0;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: table-driven transfers plus reset, drop-before-grant and timeout sequences.
module tb_spi_xfer_arbiter;
  logic clk = 1'b0, rst_i = 1'b1;
  logic [3:0] req_valid_i = '0, req_ready_o;
  logic [127:0] req_data_i;
  logic [31:0] req_ss_i;
  logic rsp_valid_o, rsp_err_o, busy_o, re_o, we_o;
  logic [1:0] rsp_id_o;
  logic [31:0] rsp_data_o, wdata_o, rdata_i = '0;
  logic [7:0] addr_o;
  logic [3:0] be_o;
  logic error_i = 1'b0, intr_i = 1'b0;
  int checks = 0, failures = 0;
  logic [31:0] dtab [4];
  logic [7:0] stab [4];
  typedef struct {
    logic [3:0] vmask;
    int id;
    int wcyc;
    int err_at;
    logic stuck;
    logic [31:0] rx;
  } vec_t;
  vec_t vt [14];
  always #5 clk = ~clk;
  spi_xfer_arbiter #(
    .NREQ(4), .SS_NB(8), .CHAR_LEN(32), .CLK_DIV(16'd1)
`ifdef SPI_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ss_i(req_ss_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i), .error_i(error_i), .intr_i(intr_i)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] bus();
    return 64'({rsp_valid_o, we_o, re_o, addr_o, wdata_o});
  endfunction
  function automatic logic [63:0] wr(input logic [7:0] a, input logic [31:0] d);
    return 64'({1'b0, 1'b1, 1'b0, a, d});
  endfunction
  task automatic xfer(input vec_t v);
    logic e;
    e = v.err_at >= 0 && v.err_at <= 3;
    req_valid_i = v.vmask;
    intr_i = v.stuck;
    #1;
    chk("grant", 64'(req_ready_o), 64'(4'b1 << v.id));
    step();
    chk("ss_write", bus(), wr(8'h18, 32'(stab[v.id])));
    error_i = v.err_at == 0;
    step();
    error_i = 1'b0;
    chk("tx_write", bus(), wr(8'h00, dtab[v.id]));
    error_i = v.err_at == 1;
    step();
    error_i = 1'b0;
    chk("ctrl_write", bus(), wr(8'h10, 32'h0000_3120));
    error_i = v.err_at == 2;
    #1;
    error_i = 1'b0;
    step();
    chk("wait_quiet", 64'({rsp_valid_o, we_o, re_o, busy_o}), 64'(4'b0001));
    for (int k = 0; k < v.wcyc; k++) begin
      intr_i = v.stuck || k == v.wcyc - 1;
      step();
    end
    intr_i = 1'b0;
    chk("rx_read", bus(), 64'({1'b0, 1'b0, 1'b1, 8'h00, 32'h0}));
    rdata_i = v.rx;
    error_i = v.err_at == 3;
    step();
    error_i = 1'b0;
    rdata_i = '0;
    chk("rsp", 64'({rsp_valid_o, rsp_err_o, rsp_id_o, rsp_data_o}),
        64'({1'b1, e, 2'(v.id), e ? 32'h0 : v.rx}));
    step();
    chk("back_idle", 64'({busy_o, rsp_valid_o}), 64'(0));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      dtab[i] = 32'hA5A5_0001 + 32'(i) * 32'h0101_0000;
      stab[i] = 8'(1 << i);
      req_data_i[i*32 +: 32] = dtab[i];
      req_ss_i[i*8 +: 8] = stab[i];
    end
    vt[0]  = '{4'b0001, 0, 40, -1, 1'b0, 32'hDEAD_BEEF};
    vt[1]  = '{4'b0001, 0, 2, 1, 1'b0, 32'h1234_5678};
    vt[2]  = '{4'b1010, 1, 3, -1, 1'b0, 32'hCAFE_0001};
    vt[3]  = '{4'b1010, 3, 2, 0, 1'b0, 32'hCAFE_0002};
    vt[4]  = '{4'b0110, 1, 2, 3, 1'b0, 32'hCAFE_0003};
    vt[5]  = '{4'b0110, 2, 2, -1, 1'b1, 32'hCAFE_0004};
    vt[6]  = '{4'b1111, 3, 2, -1, 1'b0, 32'h0000_0006};
    vt[7]  = '{4'b1111, 0, 2, -1, 1'b0, 32'h0000_0007};
    vt[8]  = '{4'b1111, 1, 4, -1, 1'b0, 32'h0000_0008};
    vt[9]  = '{4'b1111, 2, 2, -1, 1'b0, 32'h0000_0009};
    vt[10] = '{4'b1111, 3, 2, -1, 1'b0, 32'h0000_000A};
    vt[11] = '{4'b1111, 0, 2, -1, 1'b0, 32'h0000_000B};
    vt[12] = '{4'b0001, 0, 5, -1, 1'b0, 32'h0000_000C};
    vt[13] = '{4'b0011, 0, 2, -1, 1'b0, 32'h0000_000D};
    step();
    step();
    chk("reset_outputs", 64'({req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, re_o, we_o, addr_o}), 64'(0));
    chk("reset_be", 64'(be_o), 64'(4'hF));
    rst_i = 1'b0;
    step();
    chk("init_divider", bus(), wr(8'h14, 32'h1));
    step();
    chk("idle_after_init", 64'({busy_o, we_o, re_o}), 64'(0));
    for (int i = 0; i < 13; i++) xfer(vt[i]);
    req_valid_i = 4'b0100;
    #2;
    req_valid_i = '0;
    step();
    chk("drop_before_grant", 64'({busy_o, req_ready_o}), 64'(0));
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    step();
    step();
    step();
    step();
    chk("in_wait", 64'({busy_o, we_o, re_o}), 64'(3'b100));
    rst_i = 1'b1;
    step();
    chk("reset_in_wait", 64'({req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o, re_o, we_o, addr_o, wdata_o[15:0]}), 64'(0));
    rst_i = 1'b0;
    step();
    chk("reinit_divider", bus(), wr(8'h14, 32'h1));
    step();
    chk("no_rsp_after_reset", 64'({rsp_valid_o, busy_o}), 64'(0));
    xfer(vt[13]);
`ifdef SPI_ARB_TIMEOUT_EN
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    step();
    step();
    step();
    for (int k = 0; k < 63; k++) step();
    chk("timeout_ctrl_clear", bus(), wr(8'h10, 32'h0));
    step();
    chk("timeout_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'({1'b1, 1'b1, 32'h0}));
    step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
